// File: rtl/regfile_seq_ctrl.sv
// Operation sequencer for the TTM4 register file: walks one START'd operation through
// PH_A/GAP/PH_B/FIN and drives the active-low load, count and LOADBUS output strobes.
module regfile_seq_ctrl #(
  parameter int HOLD_CYCLES = 1,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [2:0] OP,
  input  logic       ABORT,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic       LB_VALID,
  output logic       LB_NIB,
  output logic       nPC_LD,
  output logic       nPC_OPEN,
  output logic       nJRD_ST,
  output logic       nJRU_ST,
  output logic       nORD_ST,
  output logic       nORU_ST,
  output logic       nJRD_OUT,
  output logic       nJRU_OUT,
  output logic       nIRD_OUT,
  output logic       nIRU_OUT
);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15 || GAP_CYCLES < 0 || GAP_CYCLES > 15) begin : g_param_err
    $error("regfile_seq_ctrl: HOLD_CYCLES must be 1..15 and GAP_CYCLES 0..15");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_PH_A,
    S_GAP,
    S_PH_B,
    S_FIN
  } state_t;

  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_STORE_JP = 3'd1;
  localparam logic [2:0] OP_STORE_OR = 3'd2;
  localparam logic [2:0] OP_JUMP     = 3'd3;
  localparam logic [2:0] OP_READ_JP  = 3'd4;
  localparam logic [2:0] OP_READ_IR  = 3'd5;
  localparam logic [2:0] OP_STEP     = 3'd6;
  localparam logic [2:0] OP_ILLEGAL  = 3'd7;

  // Counters hold "cycles remaining minus one", so terminal count is zero.
  localparam logic [3:0] LP_HOLD_RLD = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] LP_GAP_RLD  = 4'(GAP_CYCLES - 1);

  state_t     r_state, w_state_nxt;
  logic [2:0] r_op, w_op_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;

  logic r_busy, r_done, r_err, r_lb_valid, r_lb_nib;
  logic r_npc_ld, r_npc_open, r_njrd_st, r_njru_st, r_nord_st, r_noru_st;
  logic r_njrd_out, r_njru_out, r_nird_out, r_niru_out;

  logic w_busy, w_done, w_err, w_lb_valid, w_lb_nib;
  logic w_npc_ld, w_npc_open, w_njrd_st, w_njru_st, w_nord_st, w_noru_st;
  logic w_njrd_out, w_njru_out, w_nird_out, w_niru_out;

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE, S_FIN: begin
        w_state_nxt = S_IDLE;
        if (START) begin
          w_op_nxt    = OP;
          w_cnt_nxt   = (OP == OP_READ_JP || OP == OP_READ_IR) ? LP_HOLD_RLD : 4'd0;
          w_state_nxt = (OP == OP_NOP || OP == OP_ILLEGAL) ? S_FIN : S_PH_A;
        end
      end
      S_PH_A: begin
        if (ABORT) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end else if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          case (r_op)
            OP_STORE_JP, OP_STORE_OR: begin
              w_state_nxt = S_PH_B;
              w_cnt_nxt   = 4'd0;
            end
            OP_READ_JP, OP_READ_IR: begin
              if (GAP_CYCLES > 0) begin
                w_state_nxt = S_GAP;
                w_cnt_nxt   = LP_GAP_RLD;
              end else begin
                w_state_nxt = S_PH_B;
                w_cnt_nxt   = LP_HOLD_RLD;
              end
            end
            default: w_state_nxt = S_FIN;
          endcase
        end
      end
      S_GAP: begin
        if (ABORT) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end else if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_state_nxt = S_PH_B;
          w_cnt_nxt   = LP_HOLD_RLD;
        end
      end
      S_PH_B: begin
        if (ABORT) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end else if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_state_nxt = S_FIN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so each output
  // reflects the state occupied during the same cycle.
  always_comb begin
    w_busy     = 1'b0;
    w_done     = 1'b0;
    w_err      = 1'b0;
    w_lb_nib   = 1'b0;
    w_npc_ld   = 1'b1;
    w_npc_open = 1'b1;
    w_njrd_st  = 1'b1;
    w_njru_st  = 1'b1;
    w_nord_st  = 1'b1;
    w_noru_st  = 1'b1;
    w_njrd_out = 1'b1;
    w_njru_out = 1'b1;
    w_nird_out = 1'b1;
    w_niru_out = 1'b1;
    case (w_state_nxt)
      S_PH_A: begin
        w_busy = 1'b1;
        case (w_op_nxt)
          OP_STORE_JP: w_njrd_st  = 1'b0;
          OP_STORE_OR: w_nord_st  = 1'b0;
          OP_JUMP:     w_npc_ld   = 1'b0;
          OP_READ_JP:  w_njrd_out = 1'b0;
          OP_READ_IR:  w_nird_out = 1'b0;
          OP_STEP:     w_npc_open = 1'b0;
          default: ;
        endcase
      end
      S_GAP: w_busy = 1'b1;
      S_PH_B: begin
        w_busy   = 1'b1;
        w_lb_nib = 1'b1;
        case (w_op_nxt)
          OP_STORE_JP: w_njru_st  = 1'b0;
          OP_STORE_OR: w_noru_st  = 1'b0;
          OP_READ_JP:  w_njru_out = 1'b0;
          OP_READ_IR:  w_niru_out = 1'b0;
          default: ;
        endcase
      end
      S_FIN: begin
        w_done = 1'b1;
        w_err  = (w_op_nxt == OP_ILLEGAL);
      end
      default: ;
    endcase
    w_lb_valid = ~(w_njrd_out & w_njru_out & w_nird_out & w_niru_out);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_op       <= OP_NOP;
      r_cnt      <= 4'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_lb_valid <= 1'b0;
      r_lb_nib   <= 1'b0;
      r_npc_ld   <= 1'b1;
      r_npc_open <= 1'b1;
      r_njrd_st  <= 1'b1;
      r_njru_st  <= 1'b1;
      r_nord_st  <= 1'b1;
      r_noru_st  <= 1'b1;
      r_njrd_out <= 1'b1;
      r_njru_out <= 1'b1;
      r_nird_out <= 1'b1;
      r_niru_out <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_op       <= w_op_nxt;
      r_cnt      <= w_cnt_nxt;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_err      <= w_err;
      r_lb_valid <= w_lb_valid;
      r_lb_nib   <= w_lb_nib;
      r_npc_ld   <= w_npc_ld;
      r_npc_open <= w_npc_open;
      r_njrd_st  <= w_njrd_st;
      r_njru_st  <= w_njru_st;
      r_nord_st  <= w_nord_st;
      r_noru_st  <= w_noru_st;
      r_njrd_out <= w_njrd_out;
      r_njru_out <= w_njru_out;
      r_nird_out <= w_nird_out;
      r_niru_out <= w_niru_out;
    end
  end

  assign BUSY     = r_busy;
  assign DONE     = r_done;
  assign ERR      = r_err;
  assign LB_VALID = r_lb_valid;
  assign LB_NIB   = r_lb_nib;
  assign nPC_LD   = r_npc_ld;
  assign nPC_OPEN = r_npc_open;
  assign nJRD_ST  = r_njrd_st;
  assign nJRU_ST  = r_njru_st;
  assign nORD_ST  = r_nord_st;
  assign nORU_ST  = r_noru_st;
  assign nJRD_OUT = r_njrd_out;
  assign nJRU_OUT = r_njru_out;
  assign nIRD_OUT = r_nird_out;
  assign nIRU_OUT = r_niru_out;

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Bench for regfile_seq_ctrl: two instances (HOLD=2/GAP=1 and HOLD=1/GAP=0) share stimulus
// and are checked cycle by cycle against a queue of expected output vectors per operation.
module tb_regfile_seq_ctrl;

  localparam int H0 = 2, G0 = 1, H1 = 1, G1 = 0;
  // Vector bit positions of the strobes inside an expected/observed vector.
  localparam int B_PCLD = 9, B_PCOP = 8, B_JRDST = 7, B_JRUST = 6, B_ORDST = 5;
  localparam int B_ORUST = 4, B_JRDOUT = 3, B_JRUOUT = 2, B_IRDOUT = 1, B_IRUOUT = 0;
  localparam logic [14:0] IDLE_V = 15'h03FF;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RST = 1'b1, START = 1'b0, ABORT = 1'b0;
  logic [2:0] OP = 3'd0;
  logic [1:0] busy, done, err, lbv, lbn, pcld, pcop, jrdst, jrust, ordst, orust;
  logic [1:0] jrdout, jruout, irdout, iruout;

  int n_checks = 0, n_errors = 0, cyc_n = 0;
  logic mon_en = 1'b0;
  logic [14:0] exp_v [2];
  logic [14:0] q0[$], q1[$], tq[$];

  regfile_seq_ctrl #(.HOLD_CYCLES(H0), .GAP_CYCLES(G0)) u_dut0 (
    .CLK(CLK), .RST(RST), .START(START), .OP(OP), .ABORT(ABORT),
    .BUSY(busy[0]), .DONE(done[0]), .ERR(err[0]), .LB_VALID(lbv[0]), .LB_NIB(lbn[0]),
    .nPC_LD(pcld[0]), .nPC_OPEN(pcop[0]), .nJRD_ST(jrdst[0]), .nJRU_ST(jrust[0]),
    .nORD_ST(ordst[0]), .nORU_ST(orust[0]), .nJRD_OUT(jrdout[0]), .nJRU_OUT(jruout[0]),
    .nIRD_OUT(irdout[0]), .nIRU_OUT(iruout[0]));

  regfile_seq_ctrl #(.HOLD_CYCLES(H1), .GAP_CYCLES(G1)) u_dut1 (
    .CLK(CLK), .RST(RST), .START(START), .OP(OP), .ABORT(ABORT),
    .BUSY(busy[1]), .DONE(done[1]), .ERR(err[1]), .LB_VALID(lbv[1]), .LB_NIB(lbn[1]),
    .nPC_LD(pcld[1]), .nPC_OPEN(pcop[1]), .nJRD_ST(jrdst[1]), .nJRU_ST(jrust[1]),
    .nORD_ST(ordst[1]), .nORU_ST(orust[1]), .nJRD_OUT(jrdout[1]), .nJRU_OUT(jruout[1]),
    .nIRD_OUT(irdout[1]), .nIRU_OUT(iruout[1]));

  function automatic logic [9:0] strobes(int d);
    return {pcld[d], pcop[d], jrdst[d], jrust[d], ordst[d], orust[d],
            jrdout[d], jruout[d], irdout[d], iruout[d]};
  endfunction

  // LB_NIB is only meaningful while LB_VALID=1, so it is masked in the vector.
  function automatic logic [14:0] obs(int d);
    return {busy[d], done[d], err[d], lbv[d], lbv[d] & lbn[d], strobes(d)};
  endfunction

  function automatic logic [14:0] mk(logic b, logic dn, logic er, int sidx, logic nib);
    logic [9:0] s;
    logic v;
    s = 10'h3FF;
    if (sidx >= 0) s[sidx] = 1'b0;
    v = (sidx >= 0 && sidx <= 3);
    return {b, dn, er, v, v & nib, s};
  endfunction

  task automatic build(input logic [2:0] op, input int h, input int g);
    tq.delete();
    case (op)
      3'd1: begin tq.push_back(mk(1, 0, 0, B_JRDST, 0)); tq.push_back(mk(1, 0, 0, B_JRUST, 1)); end
      3'd2: begin tq.push_back(mk(1, 0, 0, B_ORDST, 0)); tq.push_back(mk(1, 0, 0, B_ORUST, 1)); end
      3'd3: tq.push_back(mk(1, 0, 0, B_PCLD, 0));
      3'd6: tq.push_back(mk(1, 0, 0, B_PCOP, 0));
      3'd4, 3'd5: begin
        for (int i = 0; i < h; i++) tq.push_back(mk(1, 0, 0, (op == 3'd4) ? B_JRDOUT : B_IRDOUT, 0));
        for (int i = 0; i < g; i++) tq.push_back(mk(1, 0, 0, -1, 0));
        for (int i = 0; i < h; i++) tq.push_back(mk(1, 0, 0, (op == 3'd4) ? B_JRUOUT : B_IRUOUT, 1));
      end
      default: ;
    endcase
    tq.push_back(mk(0, 1, (op == 3'd7), -1, 0));
  endtask

  // Drive one cycle of inputs, advance the reference model, and land #1 after the edge.
  task automatic cyc(input logic st, input logic [2:0] op, input logic ab, input logic rs);
    START = st; OP = op; ABORT = ab; RST = rs;
    for (int d = 0; d < 2; d++) begin
      logic cur_busy;
      cur_busy = exp_v[d][14];
      if (rs || (ab && cur_busy)) begin
        if (d == 0) q0.delete(); else q1.delete();
      end else if (st && !cur_busy) begin
        build(op, (d == 0) ? H0 : H1, (d == 0) ? G0 : G1);
        foreach (tq[i]) begin
          if (d == 0) q0.push_back(tq[i]); else q1.push_back(tq[i]);
        end
      end
    end
    @(posedge CLK);
    #1;
    exp_v[0] = (q0.size() > 0) ? q0.pop_front() : IDLE_V;
    exp_v[1] = (q1.size() > 0) ? q1.pop_front() : IDLE_V;
    cyc_n++;
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if ($countones(~strobes(d)) > 1) begin
          n_errors++;
          $display("FAIL exclusive dut%0d cyc%0d strobes %b want at most one low", d, cyc_n, strobes(d));
        end
      end
    end
  end

  task automatic test_reset();
    cyc(1, 3'd1, 0, 1);
    cyc(0, 3'd0, 0, 1);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (obs(d) !== IDLE_V) begin
        n_errors++;
        $display("FAIL reset dut%0d got %h want %h", d, obs(d), IDLE_V);
      end
    end
    mon_en = 1'b1;
    cyc(0, 3'd0, 0, 0);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (obs(d) !== exp_v[d]) begin
        n_errors++;
        $display("FAIL reset_release dut%0d got %h want %h", d, obs(d), exp_v[d]);
      end
    end
  endtask

  task automatic test_store();
    for (int k = 0; k < 12; k++) begin
      if (k == 0) cyc(1, 3'd1, 0, 0);
      else if (k == 6) cyc(1, 3'd2, 0, 0);
      else cyc(0, 3'($urandom_range(7)), 0, 0);
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (obs(d) !== exp_v[d]) begin
          n_errors++;
          $display("FAIL store dut%0d cyc%0d got %h want %h", d, cyc_n, obs(d), exp_v[d]);
        end
      end
    end
  endtask

  task automatic test_read();
    for (int k = 0; k < 20; k++) begin
      if (k == 0) cyc(1, 3'd5, 0, 0);
      else if (k == 10) cyc(1, 3'd4, 0, 0);
      else cyc(0, 3'd0, 0, 0);
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (obs(d) !== exp_v[d]) begin
          n_errors++;
          $display("FAIL read dut%0d cyc%0d got %h want %h", d, cyc_n, obs(d), exp_v[d]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ops [8] = '{3'd3, 3'd6, 3'd6, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    logic       sts [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 8; k++) begin
      cyc(sts[k], ops[k], 0, 0);
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (obs(d) !== exp_v[d]) begin
          n_errors++;
          $display("FAIL back_to_back dut%0d cyc%0d got %h want %h", d, cyc_n, obs(d), exp_v[d]);
        end
      end
    end
    // Continuous START with random ops: each op must follow the previous FIN directly.
    for (int k = 0; k < 30; k++) begin
      cyc(1, 3'($urandom_range(7)), 0, 0);
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (obs(d) !== exp_v[d]) begin
          n_errors++;
          $display("FAIL b2b_stream dut%0d cyc%0d got %h want %h", d, cyc_n, obs(d), exp_v[d]);
        end
      end
    end
    repeat (8) cyc(0, 3'd0, 0, 0);
  endtask

  task automatic test_illegal();
    for (int k = 0; k < 6; k++) begin
      if (k == 0) cyc(1, 3'd7, 0, 0);
      else if (k == 3) cyc(1, 3'd0, 0, 0);
      else cyc(0, 3'd0, 0, 0);
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (obs(d) !== exp_v[d]) begin
          n_errors++;
          $display("FAIL illegal dut%0d cyc%0d got %h want %h", d, cyc_n, obs(d), exp_v[d]);
        end
      end
    end
  endtask

  task automatic test_abort();
    // Abort at cycle 2 (with a competing START), at cycle 3, and an abort while idle.
    for (int a = 2; a <= 4; a++) begin
      for (int k = 0; k < 10; k++) begin
        if (k == 0) cyc(1, 3'd4, (a == 4), 0);
        else if (k == a && a != 4) cyc(a == 2, 3'd5, 1, 0);
        else cyc(0, 3'd0, 0, 0);
        for (int d = 0; d < 2; d++) begin
          n_checks++;
          if (obs(d) !== exp_v[d]) begin
            n_errors++;
            $display("FAIL abort%0d dut%0d cyc%0d got %h want %h", a, d, cyc_n, obs(d), exp_v[d]);
          end
        end
      end
    end
  endtask

  task automatic test_rst_mid();
    for (int k = 0; k < 6; k++) begin
      if (k == 0) cyc(1, 3'd2, 0, 0);
      else cyc(k == 1, 3'd1, 0, k == 1);
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (obs(d) !== exp_v[d]) begin
          n_errors++;
          $display("FAIL rst_mid dut%0d cyc%0d got %h want %h", d, cyc_n, obs(d), exp_v[d]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      cyc(($urandom_range(2) == 0), 3'($urandom_range(7)), ($urandom_range(11) == 0),
          ($urandom_range(59) == 0));
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (obs(d) !== exp_v[d]) begin
          n_errors++;
          $display("FAIL random dut%0d cyc%0d got %h want %h", d, cyc_n, obs(d), exp_v[d]);
        end
      end
    end
  endtask

  initial begin
    exp_v[0] = IDLE_V;
    exp_v[1] = IDLE_V;
    test_reset();
    test_store();
    test_read();
    test_back_to_back();
    test_illegal();
    test_abort();
    test_rst_mid();
    test_random();
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
